// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the frame FSM encoding, which the serial adder reuses, and a helper
// that sizes the bit counter.
package serial_subtractor_pkg;

    // The serial adder depends on this exact encoding, so keep the values fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The counter is $clog2(w) bits wide. A 1-bit operand still gets a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: single-bit combinational subtract, d = a - b - bin.
// Latency: zero (purely combinational).
// Backpressure: none. Ports: a, b, bin in; d (difference), bout (borrow-out) out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a is 0 and b is 1.
    // When a equals b, an incoming borrow passes straight through.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: WIDTH-bit bit-serial A - B. Operands arrive LSB first, one bit per clock.
// Latency: a start at edge k samples bit0 at edge k+1; done pulses in the cycle after edge k+WIDTH.
// Backpressure: none. A start while busy is ignored. Every pad output has a constant-1 enable.
// Ports: clk, rst_n, start, a, b in; diff/diff_en, result, borrow/borrow_en, busy, done/done_en out.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    output logic             diff,
    output logic             diff_en,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             borrow_en,
    output logic             busy,
    output logic             done,
    output logic             done_en
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_r_q, borrow_r_d;
    logic             diff_q, diff_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             borrow_q, borrow_d;

    logic fs_d, fs_bout;

    full_subtractor u_fs (
        .a    (a),
        .b    (b),
        .bin  (borrow_r_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        borrow_r_d = borrow_r_q;
        diff_d     = diff_q;
        result_d   = result_q;
        borrow_d   = borrow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts start like IDLE does, so frames can run back to back.
                if (start) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    borrow_r_d = 1'b0;
                    result_d   = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                diff_d           = fs_d;
                result_d[cnt_q]  = fs_d;
                borrow_r_d       = fs_bout;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    borrow_d = fs_bout;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            borrow_r_q <= 1'b0;
            diff_q     <= 1'b0;
            result_q   <= '0;
            borrow_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            borrow_r_q <= borrow_r_d;
            diff_q     <= diff_d;
            result_q   <= result_d;
            borrow_q   <= borrow_d;
        end
    end

    // busy and done decode the state register directly.
    // They are therefore glitch-free and read 0 during reset.
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign result    = result_q;
    assign borrow    = borrow_q;
    assign diff_en   = 1'b1;
    assign borrow_en = 1'b1;
    assign done_en   = 1'b1;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8 instance: the main device under test.
    logic       start8, a8, b8;
    logic       diff8, diff_en8, borrow8, borrow_en8, busy8, done8, done_en8;
    logic [7:0] result8;

    // WIDTH=1 and WIDTH=13 instances, used by the random test.
    logic        start1, a1, b1, diff1, diff_en1, borrow1, borrow_en1, busy1, done1, done_en1;
    logic [0:0]  result1;
    logic        start13, a13, b13, diff13, diff_en13, borrow13, borrow_en13, busy13, done13, done_en13;
    logic [12:0] result13;

    int sb8[$];
    int sb1[$];
    int sb13[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .diff(diff8), .diff_en(diff_en8), .result(result8), .borrow(borrow8),
        .borrow_en(borrow_en8), .busy(busy8), .done(done8), .done_en(done_en8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .diff(diff1), .diff_en(diff_en1), .result(result1), .borrow(borrow1),
        .borrow_en(borrow_en1), .busy(busy1), .done(done1), .done_en(done_en1)
    );

    serial_subtractor #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
        .diff(diff13), .diff_en(diff_en13), .result(result13), .borrow(borrow13),
        .borrow_en(borrow_en13), .busy(busy13), .done(done13), .done_en(done_en13)
    );

    // Drives one 8-bit frame. The task is entered at a negedge and returns at the negedge of the DONE cycle.
    // seq_ok records whether busy and done followed the expected timeline.
    // poke raises start during RUN; the DUT must ignore it.
    task automatic send_frame8(input logic [7:0] av, input logic [7:0] bv, input bit poke,
                               output logic [7:0] dser, output bit seq_ok);
        seq_ok = 1'b1;
        dser   = '0;
        start8 = 1'b1;
        @(negedge clk);
        if (busy8 !== 1'b1 || done8 !== 1'b0) seq_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a8 = av[i];
            b8 = bv[i];
            start8 = (poke && (i == 2 || i == 5)) ? 1'b1 : 1'b0;
            @(negedge clk);
            dser[i] = diff8;
            if (i < 7 && (busy8 !== 1'b1 || done8 !== 1'b0)) seq_ok = 1'b0;
        end
        start8 = 1'b0;
        a8 = 1'b0;
        b8 = 1'b0;
        if (busy8 !== 1'b0 || done8 !== 1'b1) seq_ok = 1'b0;
        sb8.push_back((int'(av) - int'(bv)) & 9'h1FF);
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        obs = {diff8, result8, borrow8, busy8, done8, diff_en8, borrow_en8, done_en8};
        checks++;
        if (obs !== 15'b0_00000000_000_111) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, 15'b0_00000000_000_111);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ds;
        bit ok;
        int exp;
        send_frame8(8'h05, 8'h03, 1'b0, ds, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_timing busy/done sequence wrong got=%0d exp=1", ok);
        end
        checks++;
        if (ds !== 8'h02) begin
            errors++;
            $display("FAIL basic_serial_diff got=%b exp=%b", ds, 8'h02);
        end
        exp = sb8.pop_front();
        checks++;
        if (int'({borrow8, result8}) !== exp) begin
            errors++;
            $display("FAIL basic_result got=%h exp=%h", {borrow8, result8}, exp);
        end
        @(negedge clk);
        checks++;
        if ({result8, borrow8, done8, busy8, diff8} !== {8'h02, 4'b0000}) begin
            errors++;
            $display("FAIL basic_hold got=%b exp=%b", {result8, borrow8, done8, busy8, diff8}, {8'h02, 4'b0000});
        end
    endtask

    task automatic test_negative();
        logic [7:0] ds;
        bit ok;
        int exp;
        send_frame8(8'h03, 8'h05, 1'b0, ds, ok);
        exp = sb8.pop_front();
        checks++;
        if (int'({borrow8, result8}) !== exp || exp !== 9'h1FE) begin
            errors++;
            $display("FAIL negative_result got=%h exp=%h", {borrow8, result8}, 9'h1FE);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_ripple();
        logic [7:0] ds;
        bit ok;
        int exp;
        send_frame8(8'h00, 8'h00, 1'b0, ds, ok);
        exp = sb8.pop_front();
        checks++;
        if (int'({borrow8, result8}) !== exp) begin
            errors++;
            $display("FAIL zero_result got=%h exp=%h", {borrow8, result8}, exp);
        end
        @(negedge clk);
        send_frame8(8'h00, 8'h01, 1'b0, ds, ok);
        exp = sb8.pop_front();
        checks++;
        if (int'({borrow8, result8}) !== exp || ds !== 8'hFF) begin
            errors++;
            $display("FAIL ripple_result got=%h/%h exp=%h/%h", {borrow8, result8}, ds, exp, 8'hFF);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ds;
        bit ok;
        int exp;
        send_frame8(8'h0F, 8'h01, 1'b0, ds, ok);
        exp = sb8.pop_front();
        checks++;
        if (int'({borrow8, result8}) !== exp) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=%h", {borrow8, result8}, exp);
        end
        // The second frame starts in the DONE cycle. It also pokes start mid-frame.
        send_frame8(8'h10, 8'h20, 1'b1, ds, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_timing busy gap or early/late done got=%0d exp=1", ok);
        end
        exp = sb8.pop_front();
        checks++;
        if (int'({borrow8, result8}) !== exp) begin
            errors++;
            $display("FAIL b2b_second got=%h exp=%h", {borrow8, result8}, exp);
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL poke_ignored busy got=%b exp=0", busy8);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] ds;
        logic [7:0] av;
        logic [7:0] bv;
        logic [14:0] obs;
        bit ok;
        int exp;
        av = 8'hAA;
        bv = 8'h55;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a8 = av[i];
            b8 = bv[i];
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        obs = {diff8, result8, borrow8, busy8, done8, diff_en8, borrow_en8, done_en8};
        checks++;
        if (obs !== 15'b0_00000000_000_111) begin
            errors++;
            $display("FAIL midframe_reset got=%b exp=%b", obs, 15'b0_00000000_000_111);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 1'b0;
        b8 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle busy/done got=%b%b exp=00", busy8, done8);
        end
        send_frame8(av, bv, 1'b0, ds, ok);
        exp = sb8.pop_front();
        checks++;
        if (int'({borrow8, result8}) !== exp || exp !== 9'h055) begin
            errors++;
            $display("FAIL post_reset_frame got=%h exp=%h", {borrow8, result8}, 9'h055);
        end
        @(negedge clk);
    endtask

    // Starts all three widths together every iteration. Each done pulse pops that instance's scoreboard.
    task automatic test_random();
        logic [12:0] av1, bv1, av8, bv8, av13, bv13;
        int n1, n8, n13, exp;
        for (int it = 0; it < 1000; it++) begin
            av1  = 13'($urandom_range(0, 1));
            bv1  = 13'($urandom_range(0, 1));
            av8  = 13'($urandom_range(0, 255));
            bv8  = 13'($urandom_range(0, 255));
            av13 = 13'($urandom_range(0, 8191));
            bv13 = 13'($urandom_range(0, 8191));
            sb1.push_back((int'(av1) - int'(bv1)) & 3);
            sb8.push_back((int'(av8) - int'(bv8)) & 9'h1FF);
            sb13.push_back((int'(av13) - int'(bv13)) & 14'h3FFF);
            n1 = 0; n8 = 0; n13 = 0;
            start1 = 1'b1; start8 = 1'b1; start13 = 1'b1;
            @(negedge clk);
            start1 = 1'b0; start8 = 1'b0; start13 = 1'b0;
            for (int i = 0; i < 13; i++) begin
                a1  = (i < 1) ? av1[i] : 1'b0;
                b1  = (i < 1) ? bv1[i] : 1'b0;
                a8  = (i < 8) ? av8[i] : 1'b0;
                b8  = (i < 8) ? bv8[i] : 1'b0;
                a13 = av13[i];
                b13 = bv13[i];
                @(negedge clk);
                if (done1 === 1'b1) begin
                    n1++;
                    exp = sb1.pop_front();
                    checks++;
                    if (int'({borrow1, result1}) !== exp || i != 0) begin
                        errors++;
                        $display("FAIL rand_w1 it=%0d bit=%0d got=%h exp=%h", it, i, {borrow1, result1}, exp);
                    end
                end
                if (done8 === 1'b1) begin
                    n8++;
                    exp = sb8.pop_front();
                    checks++;
                    if (int'({borrow8, result8}) !== exp || i != 7) begin
                        errors++;
                        $display("FAIL rand_w8 it=%0d bit=%0d got=%h exp=%h", it, i, {borrow8, result8}, exp);
                    end
                end
                if (done13 === 1'b1) begin
                    n13++;
                    exp = sb13.pop_front();
                    checks++;
                    if (int'({borrow13, result13}) !== exp || i != 12) begin
                        errors++;
                        $display("FAIL rand_w13 it=%0d bit=%0d got=%h exp=%h", it, i, {borrow13, result13}, exp);
                    end
                end
            end
            checks++;
            if (n1 != 1 || n8 != 1 || n13 != 1) begin
                errors++;
                $display("FAIL rand_done_count it=%0d got=%0d/%0d/%0d exp=1/1/1", it, n1, n8, n13);
                sb1.delete(); sb8.delete(); sb13.delete();
            end
        end
        a1 = 1'b0; b1 = 1'b0; a8 = 1'b0; b8 = 1'b0; a13 = 1'b0; b13 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 1'b0; b8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        start13 = 1'b0; a13 = 1'b0; b13 = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_negative();
        test_zero_ripple();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
